// File: rtl/mem_data_reg_ext.sv
// Memory data register: captures a read response under a start/valid handshake and
// extracts the addressed byte/half/word/dword with sign or zero extension.
module mem_data_reg_ext #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ld_start,
    input  logic [1:0]                  i_size,
    input  logic                        i_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0] i_addr_lo,
    input  logic                        i_mem_valid,
    input  logic [DATA_W-1:0]           i_mem_data,
    input  logic                        i_flush,
    output logic                        o_busy,
    output logic                        o_valid,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_err_align,
    output logic                        o_err_timeout
);
    localparam int LO_W = $clog2(DATA_W/8);
    // A disabled timeout still gets a 1-bit timer so no zero-width vectors appear.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMR_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]        state_reg;
    logic [1:0]        size_reg;
    logic              zext_reg;
    logic [LO_W-1:0]   addr_lo_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic              valid_reg;
    logic              err_align_reg;
    logic              err_timeout_reg;
    logic [DATA_W-1:0] data_reg;

    logic              align_ok;
    logic [DATA_W-1:0] shifted;
    logic [63:0]       mask_wide;
    logic [DATA_W-1:0] mask;
    logic              sign_bit;
    logic              fill;
    logic [DATA_W-1:0] extracted;

    always_comb begin
        align_ok = 1'b0;
        case (i_size)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~i_addr_lo[0];
            2'b10:   align_ok = (i_addr_lo[1:0] == 2'b00);
            default: align_ok = (DATA_W == 64) && (i_addr_lo == '0);
        endcase
    end

    // Shift the addressed lane down to bit 0, then keep or fill the bits above the access size.
    always_comb begin
        shifted   = i_mem_data >> {addr_lo_reg, 3'b000};
        mask_wide = '1;
        sign_bit  = shifted[DATA_W-1];
        case (size_reg)
            2'b00: begin mask_wide = 64'h0000_0000_0000_00FF; sign_bit = shifted[7];  end
            2'b01: begin mask_wide = 64'h0000_0000_0000_FFFF; sign_bit = shifted[15]; end
            2'b10: begin mask_wide = 64'h0000_0000_FFFF_FFFF; sign_bit = shifted[31]; end
            default: begin mask_wide = '1; sign_bit = shifted[DATA_W-1]; end
        endcase
        mask = mask_wide[DATA_W-1:0];
        fill = ~zext_reg & sign_bit;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            assign extracted[gi] = mask[gi] ? shifted[gi] : fill;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            size_reg        <= '0;
            zext_reg        <= 1'b0;
            addr_lo_reg     <= '0;
            timer_reg       <= '0;
            valid_reg       <= 1'b0;
            err_align_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            data_reg        <= '0;
        end else begin
            valid_reg       <= 1'b0;
            err_align_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            if (i_flush) begin
                state_reg <= IDLE;
                timer_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (i_ld_start) begin
                    if (align_ok) begin
                        size_reg    <= i_size;
                        zext_reg    <= i_unsigned;
                        addr_lo_reg <= i_addr_lo;
                        timer_reg   <= '0;
                        state_reg   <= WAIT;
                    end else begin
                        err_align_reg <= 1'b1;
                    end
                end
            end else begin
                // A response arriving on the expiry edge takes precedence over the timeout.
                if (i_mem_valid) begin
                    data_reg  <= extracted;
                    valid_reg <= 1'b1;
                    timer_reg <= '0;
                    state_reg <= IDLE;
                end else if ((TIMEOUT != 0) && (timer_reg == TMR_LAST[TMR_W-1:0])) begin
                    err_timeout_reg <= 1'b1;
                    timer_reg       <= '0;
                    state_reg       <= IDLE;
                end else begin
                    timer_reg <= timer_reg + TMR_W'(1);
                end
            end
        end
    end

    assign o_busy        = (state_reg == WAIT);
    assign o_valid       = valid_reg;
    assign o_data        = data_reg;
    assign o_err_align   = err_align_reg;
    assign o_err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_mem_data_reg_ext.sv
// Scoreboard bench for mem_data_reg_ext: a 32-bit instance with a short timeout and a 64-bit instance.
module tb_mem_data_reg_ext;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_ld_start, a_unsigned, a_mem_valid, a_flush;
    logic [1:0]  a_size, a_addr_lo;
    logic [31:0] a_mem_data, a_data;
    logic        a_busy, a_valid, a_err_align, a_err_to;

    logic        b_rst, b_ld_start, b_unsigned, b_mem_valid, b_flush;
    logic [1:0]  b_size;
    logic [2:0]  b_addr_lo;
    logic [63:0] b_mem_data, b_data;
    logic        b_busy, b_valid, b_err_align, b_err_to;

    mem_data_reg_ext #(.DATA_W(32), .TIMEOUT(4)) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_ld_start(a_ld_start), .i_size(a_size),
        .i_unsigned(a_unsigned), .i_addr_lo(a_addr_lo), .i_mem_valid(a_mem_valid),
        .i_mem_data(a_mem_data), .i_flush(a_flush), .o_busy(a_busy), .o_valid(a_valid),
        .o_data(a_data), .o_err_align(a_err_align), .o_err_timeout(a_err_to)
    );

    mem_data_reg_ext #(.DATA_W(64), .TIMEOUT(16)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_ld_start(b_ld_start), .i_size(b_size),
        .i_unsigned(b_unsigned), .i_addr_lo(b_addr_lo), .i_mem_valid(b_mem_valid),
        .i_mem_data(b_mem_data), .i_flush(b_flush), .o_busy(b_busy), .o_valid(b_valid),
        .o_data(b_data), .o_err_align(b_err_align), .o_err_timeout(b_err_to)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_a[$];
    logic [63:0] sb_b[$];
    logic [31:0] a_last;
    logic [63:0] b_last;
    int a_vcnt = 0, b_vcnt = 0, a_exp_v = 0, b_exp_v = 0;
    logic [63:0] a_pop, b_pop;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitors: every o_valid pops one scoreboard entry.
    always @(negedge clk) begin
        if (a_valid | a_err_align | a_err_to)
            check_val("a_excl", 64'($onehot({a_valid, a_err_align, a_err_to})), 64'd1);
        if (a_valid) begin
            a_vcnt++;
            check_val("a_sb_nonempty", 64'(sb_a.size() > 0), 64'd1);
            if (sb_a.size() > 0) begin
                a_pop = sb_a.pop_front();
                $display("a capture: data=%h expected=%h", a_data, a_pop[31:0]);
                check_val("a_data", 64'(a_data), a_pop);
            end
        end
        if (b_valid | b_err_align | b_err_to)
            check_val("b_excl", 64'($onehot({b_valid, b_err_align, b_err_to})), 64'd1);
        if (b_valid) begin
            b_vcnt++;
            check_val("b_sb_nonempty", 64'(sb_b.size() > 0), 64'd1);
            if (sb_b.size() > 0) begin
                b_pop = sb_b.pop_front();
                $display("b capture: data=%h expected=%h", b_data, b_pop);
                check_val("b_data", b_data, b_pop);
            end
        end
    end

    task automatic a_issue(input logic [1:0] sz, input logic u, input logic [1:0] lo);
        a_ld_start = 1'b1; a_size = sz; a_unsigned = u; a_addr_lo = lo;
        @(posedge clk); #1;
        a_ld_start = 1'b0;
    endtask

    // Returns one tick after the capture edge, i.e. inside the o_valid cycle.
    task automatic a_load(input logic [1:0] sz, input logic u, input logic [1:0] lo,
                          input logic [31:0] d, input logic [31:0] exp, input int gap);
        a_issue(sz, u, lo);
        check_val("a_busy", 64'(a_busy), 64'd1);
        repeat (gap) begin @(posedge clk); #1; end
        a_mem_valid = 1'b1; a_mem_data = d; sb_a.push_back(64'(exp));
        @(posedge clk); #1;
        a_mem_valid = 1'b0;
        check_val("a_valid", 64'(a_valid), 64'd1);
        check_val("a_busy_done", 64'(a_busy), 64'd0);
        a_last = exp; a_exp_v++;
    endtask

    task automatic a_idle();
        @(posedge clk); #1;
        check_val("a_valid_drop", 64'(a_valid), 64'd0);
    endtask

    task automatic a_bad(input logic [1:0] sz, input logic [1:0] lo);
        a_issue(sz, 1'b0, lo);
        check_val("a_err_align", 64'(a_err_align), 64'd1);
        check_val("a_bad_busy", 64'(a_busy), 64'd0);
        check_val("a_bad_data", 64'(a_data), 64'(a_last));
        @(posedge clk); #1;
        check_val("a_err_align_drop", 64'(a_err_align), 64'd0);
    endtask

    task automatic b_load(input logic [1:0] sz, input logic u, input logic [2:0] lo,
                          input logic [63:0] d, input logic [63:0] exp);
        b_ld_start = 1'b1; b_size = sz; b_unsigned = u; b_addr_lo = lo;
        @(posedge clk); #1;
        b_ld_start = 1'b0;
        check_val("b_busy", 64'(b_busy), 64'd1);
        b_mem_valid = 1'b1; b_mem_data = d; sb_b.push_back(exp);
        @(posedge clk); #1;
        b_mem_valid = 1'b0;
        check_val("b_valid", 64'(b_valid), 64'd1);
        b_last = exp; b_exp_v++;
        @(posedge clk); #1;
        check_val("b_valid_drop", 64'(b_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_ld_start = 1'b0; a_unsigned = 1'b0; a_mem_valid = 1'b0; a_flush = 1'b0;
        a_size = '0; a_addr_lo = '0; a_mem_data = '0; a_last = '0;
        b_rst = 1'b1; b_ld_start = 1'b0; b_unsigned = 1'b0; b_mem_valid = 1'b0; b_flush = 1'b0;
        b_size = '0; b_addr_lo = '0; b_mem_data = '0; b_last = '0;
        #12;
        check_val("a_rst_busy", 64'(a_busy), 64'd0);
        check_val("a_rst_valid", 64'(a_valid), 64'd0);
        check_val("a_rst_data", 64'(a_data), 64'd0);
        check_val("a_rst_errs", 64'({a_err_align, a_err_to}), 64'd0);
        check_val("b_rst_data", b_data, 64'd0);
        check_val("b_rst_busy", 64'(b_busy), 64'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;

        // Stray memory response in IDLE is ignored.
        a_mem_valid = 1'b1; a_mem_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        a_mem_valid = 1'b0;
        check_val("a_idle_ignore_valid", 64'(a_valid), 64'd0);
        check_val("a_idle_ignore_data", 64'(a_data), 64'd0);

        a_load(2'b00, 1'b0, 2'd1, 32'h1234_80FF, 32'hFFFF_FF80, 1); a_idle();
        a_load(2'b00, 1'b1, 2'd1, 32'h1234_80FF, 32'h0000_0080, 0); a_idle();
        a_load(2'b01, 1'b0, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 2); a_idle();
        a_bad(2'b01, 2'd1);
        a_bad(2'b10, 2'd2);
        a_bad(2'b11, 2'd0);
        a_load(2'b10, 1'b0, 2'd0, 32'hF000_0001, 32'hF000_0001, 0); a_idle();
        a_load(2'b00, 1'b0, 2'd3, 32'h7F00_0000, 32'h0000_007F, 0); a_idle();
        a_load(2'b01, 1'b1, 2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 0); a_idle();
        a_load(2'b01, 1'b0, 2'd0, 32'h0000_FFFF, 32'hFFFF_FFFF, 3); a_idle();

        // Back-to-back: second start lands in the o_valid cycle of the first.
        a_load(2'b00, 1'b0, 2'd2, 32'h00A5_0000, 32'hFFFF_FFA5, 0);
        a_load(2'b01, 1'b1, 2'd0, 32'h1234_C3C3, 32'h0000_C3C3, 1); a_idle();

        // Start during WAIT is ignored, including an illegal one.
        a_issue(2'b00, 1'b0, 2'd0);
        a_ld_start = 1'b1; a_size = 2'b01; a_unsigned = 1'b1; a_addr_lo = 2'd1;
        @(posedge clk); #1;
        a_ld_start = 1'b0;
        check_val("a_wait_no_align_err", 64'(a_err_align), 64'd0);
        check_val("a_wait_still_busy", 64'(a_busy), 64'd1);
        a_mem_valid = 1'b1; a_mem_data = 32'h0000_0081; sb_a.push_back(64'h0000_0000_FFFF_FF81);
        @(posedge clk); #1;
        a_mem_valid = 1'b0; a_last = 32'hFFFF_FF81; a_exp_v++;
        check_val("a_wait_ignore_valid", 64'(a_valid), 64'd1);
        a_idle();

        // Timeout after four idle WAIT cycles.
        a_issue(2'b10, 1'b0, 2'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check_val("a_to_early", 64'(a_err_to), 64'd0);
            check_val("a_to_busy", 64'(a_busy), 64'd1);
        end
        @(posedge clk); #1;
        check_val("a_to_pulse", 64'(a_err_to), 64'd1);
        check_val("a_to_idle", 64'(a_busy), 64'd0);
        check_val("a_to_data", 64'(a_data), 64'(a_last));
        @(posedge clk); #1;
        check_val("a_to_drop", 64'(a_err_to), 64'd0);

        // Response on the expiry edge wins.
        a_load(2'b10, 1'b0, 2'd0, 32'h1357_9BDF, 32'h1357_9BDF, 3);
        check_val("a_race_no_to", 64'(a_err_to), 64'd0);
        a_idle();

        // Flush beats a simultaneous response.
        a_issue(2'b00, 1'b0, 2'd0);
        a_flush = 1'b1; a_mem_valid = 1'b1; a_mem_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        a_flush = 1'b0; a_mem_valid = 1'b0;
        check_val("a_flush_busy", 64'(a_busy), 64'd0);
        check_val("a_flush_valid", 64'(a_valid), 64'd0);
        check_val("a_flush_data", 64'(a_data), 64'(a_last));
        a_idle();
        a_flush = 1'b1; a_ld_start = 1'b1; a_size = 2'b00;
        @(posedge clk); #1;
        a_flush = 1'b0; a_ld_start = 1'b0;
        check_val("a_flush_blocks_start", 64'(a_busy), 64'd0);

        // Asynchronous reset mid-WAIT clears outputs without waiting for a clock edge.
        a_issue(2'b00, 1'b1, 2'd3);
        #2;
        a_rst = 1'b1;
        #1;
        check_val("a_arst_busy", 64'(a_busy), 64'd0);
        check_val("a_arst_data", 64'(a_data), 64'd0);
        check_val("a_arst_pulses", 64'({a_valid, a_err_align, a_err_to}), 64'd0);
        a_last = '0;
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_load(2'b00, 1'b0, 2'd0, 32'h0000_0042, 32'h0000_0042, 0); a_idle();

        // 64-bit instance.
        b_load(2'b11, 1'b0, 3'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        b_load(2'b10, 1'b0, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        b_load(2'b01, 1'b1, 3'd6, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD);
        b_load(2'b00, 1'b0, 3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        b_ld_start = 1'b1; b_size = 2'b11; b_addr_lo = 3'd4;
        @(posedge clk); #1;
        b_ld_start = 1'b0;
        check_val("b_err_align", 64'(b_err_align), 64'd1);
        check_val("b_bad_busy", 64'(b_busy), 64'd0);
        check_val("b_bad_data", b_data, b_last);

        repeat (3) @(posedge clk);
        #1;
        check_val("a_sb_empty", 64'(sb_a.size()), 64'd0);
        check_val("b_sb_empty", 64'(sb_b.size()), 64'd0);
        check_val("a_valid_count", 64'(a_vcnt), 64'(a_exp_v));
        check_val("b_valid_count", 64'(b_vcnt), 64'(b_exp_v));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
